// File: rtl/dma_pkg.sv
// Shared definitions for the single-channel DMA controller:
// FSM state codes and configuration register select codes.
package dma_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_REL  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [1:0] SEL_SRC = 2'd0;
  localparam logic [1:0] SEL_DST = 2'd1;
  localparam logic [1:0] SEL_LEN = 2'd2;

endpackage

// File: rtl/dma_controller.sv
// Single-channel memory-to-memory DMA engine with burst-limited
// bus tenures and retry of accesses interrupted by grant loss.
module dma_controller
  import dma_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [ADDR_W-1:0] cfg_wdata,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              dma_req,
  input  logic              bus_grant,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rd,
  output logic              bus_wr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  localparam int BW = $clog2(BURST_LEN + 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] src_cfg_q, src_cfg_d;
  logic [ADDR_W-1:0] dst_cfg_q, dst_cfg_d;
  logic [ADDR_W-1:0] len_cfg_q, len_cfg_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wpend_q, wpend_d;

  always_comb begin
    state_d   = state_q;
    src_cfg_d = src_cfg_q;
    dst_cfg_d = dst_cfg_q;
    len_cfg_d = len_cfg_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    burst_d   = burst_q;
    data_d    = data_q;
    wpend_d   = wpend_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          unique case (cfg_sel)
            SEL_SRC: src_cfg_d = cfg_wdata;
            SEL_DST: dst_cfg_d = cfg_wdata;
            SEL_LEN: len_cfg_d = cfg_wdata;
            default: ;
          endcase
        end
        if (start) begin
          if (len_cfg_q == '0) begin
            state_d = S_DONE;
          end else begin
            src_d   = src_cfg_q;
            dst_d   = dst_cfg_q;
            rem_d   = len_cfg_q;
            burst_d = '0;
            wpend_d = 1'b0;
            state_d = S_REQ;
          end
        end
      end
      // wpend_q remembers that the read half already completed,
      // so a grant loss during WR resumes with the write.
      S_REQ: begin
        if (bus_grant) state_d = wpend_q ? S_WR : S_RD;
      end
      S_RD: begin
        if (!bus_grant) begin
          state_d = S_REQ;
        end else if (bus_ack) begin
          data_d  = bus_rdata;
          wpend_d = 1'b1;
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (!bus_grant) begin
          state_d = S_REQ;
        end else if (bus_ack) begin
          src_d   = src_q + 1'b1;
          dst_d   = dst_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          burst_d = burst_q + 1'b1;
          wpend_d = 1'b0;
          if (rem_q == ADDR_W'(1))
            state_d = S_DONE;
          else if (burst_q == BW'(BURST_LEN - 1))
            state_d = S_REL;
          else
            state_d = S_RD;
        end
      end
      S_REL: begin
        burst_d = '0;
        state_d = S_REQ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      src_cfg_q <= '0;
      dst_cfg_q <= '0;
      len_cfg_q <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      burst_q   <= '0;
      data_q    <= '0;
      wpend_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_cfg_q <= src_cfg_d;
      dst_cfg_q <= dst_cfg_d;
      len_cfg_q <= len_cfg_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      burst_q   <= burst_d;
      data_q    <= data_d;
      wpend_q   <= wpend_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign dma_req = (state_q == S_REQ) || (state_q == S_RD) ||
                   (state_q == S_WR);
  // Strobes are gated by grant so they vanish in the cycle it drops.
  assign bus_rd    = (state_q == S_RD) && bus_grant;
  assign bus_wr    = (state_q == S_WR) && bus_grant;
  assign bus_addr  = bus_rd ? src_q : (bus_wr ? dst_q : '0);
  assign bus_wdata = bus_wr ? data_q : '0;

endmodule

// File: tb/tb_dma_controller.sv
// Directed and randomized checks of dma_controller against a
// word-list reference model and a behavioural bus slave.
module tb_dma_controller;
  import dma_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_sel = 2'd0;
  logic [AW-1:0] cfg_wdata = '0;
  logic          start = 1'b0;
  logic          busy, done, dma_req;
  logic          bus_grant = 1'b0;
  logic [AW-1:0] bus_addr;
  logic          bus_rd, bus_wr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata = '0;
  logic          bus_ack = 1'b0;

  dma_controller #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_wdata(cfg_wdata), .start(start), .busy(busy), .done(done),
    .dma_req(dma_req), .bus_grant(bus_grant), .bus_addr(bus_addr),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  int gmode = 0;
  int amode = 1;
  int drop_at = -1;

  int drop_cnt = 0;
  int seen_evt = 0;

  int last_drop = -1;
  int drop_evt = 0;
  bit probe = 1'b0;
  bit probe_seen = 1'b0;
  logic [1:0] probe_val = 2'b11;
  logic [AW-1:0] int_addr = '0;
  logic [DW-1:0] int_data = '0;
  logic [AW-1:0] wr_a[$];
  logic [DW-1:0] wr_d[$];
  logic [AW-1:0] rd_a[$];
  int done_cnt = 0;
  int rel_cnt = 0;
  int req_cnt = 0;
  int viol_cnt = 0;
  int strb_cnt = 0;

  logic [AW-1:0] m_src = '0;
  logic [AW-1:0] m_dst = '0;
  int            m_len = 0;

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Arbiter model: held, random, or a 3-cycle drop on request.
  always @(posedge clk) begin
    #1;
    case (gmode)
      0: bus_grant = 1'b1;
      1: bus_grant = ($urandom_range(3) != 0);
      2: begin
        if (drop_evt != seen_evt) begin
          seen_evt = drop_evt;
          drop_cnt = 3;
        end
        if (drop_cnt > 0) begin
          bus_grant = 1'b0;
          drop_cnt--;
        end else begin
          bus_grant = 1'b1;
        end
      end
      default: bus_grant = 1'b0;
    endcase
  end

  // Memory slave and monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    logic ack;
    if (probe) begin
      probe_val = {bus_rd, bus_wr};
      probe = 1'b0;
      probe_seen = 1'b1;
    end
    if ((bus_rd && bus_wr) || ((bus_rd || bus_wr) && !bus_grant))
      viol_cnt++;
    if (bus_rd || bus_wr) strb_cnt++;
    if (done) done_cnt++;
    if (dma_req) req_cnt++;
    if (busy && !done && !dma_req) rel_cnt++;
    bus_rdata = mem(bus_addr);
    if (bus_rd || bus_wr) begin
      case (amode)
        0: ack = 1'b0;
        1: ack = 1'b1;
        default: ack = ($urandom_range(1) == 1);
      endcase
      if (bus_wr && wr_a.size() == drop_at && last_drop != drop_at) begin
        last_drop = drop_at;
        ack = 1'b0;
        probe = 1'b1;
        int_addr = bus_addr;
        int_data = bus_wdata;
        drop_evt++;
      end
    end else begin
      ack = (amode == 2) ? ($urandom_range(7) == 0) : 1'b0;
    end
    bus_ack = ack;
    if (bus_ack && bus_rd) rd_a.push_back(bus_addr);
    if (bus_ack && bus_wr) begin
      wr_a.push_back(bus_addr);
      wr_d.push_back(bus_wdata);
    end
  end

  task automatic cfg_write(input logic [1:0] sel,
                           input logic [AW-1:0] val);
    @(posedge clk); #1;
    cfg_we = 1'b1;
    cfg_sel = sel;
    cfg_wdata = val;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_xfer(input bit prog, input logic [AW-1:0] s,
                          input logic [AW-1:0] d, input int len,
                          input bit poke);
    int wb, rb, d0, r0, q0, v0, t, exp_rel;
    logic [AW-1:0] ea;
    wb = wr_a.size();
    rb = rd_a.size();
    d0 = done_cnt;
    r0 = rel_cnt;
    q0 = req_cnt;
    v0 = viol_cnt;
    if (prog) begin
      cfg_write(SEL_SRC, s);
      cfg_write(SEL_DST, d);
      cfg_write(SEL_LEN, AW'(len));
      m_src = s;
      m_dst = d;
      m_len = len;
    end
    pulse_start();
    @(negedge clk);
    check("busy_after_start", busy, 1);
    if (m_len != 0) check("req_after_start", dma_req, 1);
    else check("done_after_len0", done, 1);
    if (poke) begin
      cfg_write(SEL_SRC, 16'h5555);
      cfg_write(SEL_LEN, 16'd7);
      pulse_start();
    end
    t = 0;
    while (done !== 1'b1 && t < 60 * m_len + 50) begin
      @(negedge clk);
      t++;
    end
    check("done_timeout", done, 1);
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);
    check("wr_count", wr_a.size() - wb, m_len);
    check("rd_count", rd_a.size() - rb, m_len);
    for (int i = 0; i < m_len && wb + i < wr_a.size(); i++) begin
      ea = m_dst + AW'(i);
      check("wr_addr", wr_a[wb + i], ea);
      ea = m_src + AW'(i);
      check("wr_data", wr_d[wb + i], mem(ea));
    end
    for (int i = 0; i < m_len && rb + i < rd_a.size(); i++) begin
      ea = m_src + AW'(i);
      check("rd_addr", rd_a[rb + i], ea);
    end
    check("done_once", done_cnt - d0, 1);
    exp_rel = (m_len == 0) ? 0 : (m_len - 1) / BL;
    check("rel_cycles", rel_cnt - r0, exp_rel);
    if (m_len == 0) check("no_req_len0", req_cnt - q0, 0);
    check("strobe_rules", viol_cnt - v0, 0);
  endtask

  initial begin
    int t, d0, s0, wb;
    logic [AW-1:0] rs, rdst;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req", dma_req, 0);
    check("rst_rd", bus_rd, 0);
    check("rst_wr", bus_wr, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_wdata", bus_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    gmode = 0;
    amode = 1;
    run_xfer(1'b1, 16'h0010, 16'h0100, 3, 1'b0);
    run_xfer(1'b1, 16'h0200, 16'h0300, 10, 1'b0);

    gmode = 2;
    drop_at = wr_a.size() + 1;
    run_xfer(1'b1, 16'h0040, 16'h0080, 4, 1'b0);
    check("drop_seen", probe_seen, 1);
    check("drop_strobes", probe_val, 0);
    check("drop_addr", int_addr, 16'h0081);
    check("drop_data", int_data, mem(16'h0041));
    drop_at = -1;

    gmode = 0;
    run_xfer(1'b1, 16'hFFFF, 16'h0500, 2, 1'b0);
    check("wrap_rd", rd_a[rd_a.size() - 1], 16'h0000);
    run_xfer(1'b1, 16'h0600, 16'h0700, 0, 1'b0);

    gmode = 1;
    amode = 2;
    run_xfer(1'b1, 16'h0800, 16'h0900, 8, 1'b1);
    run_xfer(1'b0, 16'h0000, 16'h0000, 0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      rs = AW'($urandom);
      rdst = AW'($urandom);
      run_xfer(1'b1, rs, rdst, $urandom_range(20, 1), 1'b0);
    end

    // Abort while stuck in RD; config must come back cleared.
    gmode = 0;
    amode = 0;
    cfg_write(SEL_SRC, 16'h1234);
    cfg_write(SEL_DST, 16'h2000);
    cfg_write(SEL_LEN, 16'd4);
    pulse_start();
    t = 0;
    while (bus_rd !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("rd_reached", bus_rd, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_req", dma_req, 0);
    check("abort_rd", bus_rd, 0);
    check("abort_wr", bus_wr, 0);
    check("abort_addr", bus_addr, 0);
    check("abort_wdata", bus_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    amode = 1;
    d0 = done_cnt;
    s0 = strb_cnt;
    wb = wr_a.size();
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_strobe", strb_cnt - s0, 0);
    check("abort_no_write", wr_a.size() - wb, 0);
    m_src = '0;
    m_dst = '0;
    m_len = 0;
    run_xfer(1'b0, 16'h0000, 16'h0000, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
